// File: rtl/mc_ctrl_defs.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes, opcodes,
// ALU operation codes and datapath mux selects.
package mc_ctrl_defs;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        ClsJump,
        ClsJumpLink,
        ClsJreg,
        ClsJregLink,
        ClsBranch,
        ClsLoad,
        ClsStore,
        ClsRtype,
        ClsItype,
        ClsUndef
    } instr_class_e;

    localparam logic [5:0] OpRtype = 6'd0;
    localparam logic [5:0] OpJ     = 6'd2;
    localparam logic [5:0] OpJal   = 6'd3;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpAddi  = 6'd8;
    localparam logic [5:0] OpAddiu = 6'd9;
    localparam logic [5:0] OpSlti  = 6'd10;
    localparam logic [5:0] OpAndi  = 6'd12;
    localparam logic [5:0] OpLui   = 6'd15;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;

    localparam logic [5:0] FnSll  = 6'd0;
    localparam logic [5:0] FnSrl  = 6'd2;
    localparam logic [5:0] FnSra  = 6'd3;
    localparam logic [5:0] FnJr   = 6'd8;
    localparam logic [5:0] FnJalr = 6'd9;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluRtype = 4'd2;
    localparam logic [3:0] AluAnd   = 4'd3;
    localparam logic [3:0] AluSlt   = 4'd4;

    localparam logic [1:0] MemtoRegAluOut = 2'd0;
    localparam logic [1:0] MemtoRegMdr    = 2'd1;
    localparam logic [1:0] MemtoRegPc     = 2'd2;

    localparam logic [1:0] RegDstRt = 2'd0;
    localparam logic [1:0] RegDstRd = 2'd1;
    localparam logic [1:0] RegDstRa = 2'd2;

    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcAReg   = 2'd1;
    localparam logic [1:0] SrcAShamt = 2'd2;

    localparam logic [1:0] SrcBReg    = 2'd0;
    localparam logic [1:0] SrcBFour   = 2'd1;
    localparam logic [1:0] SrcBImm    = 2'd2;
    localparam logic [1:0] SrcBImmSl2 = 2'd3;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcRs     = 2'd3;

    // Shift-by-immediate R-types take shamt rather than rs on the A port.
    function automatic logic is_shamt_shift(input logic [5:0] funct);
        return (funct == FnSll) || (funct == FnSrl) || (funct == FnSra);
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: maps OpCode/Funct onto the class the
// control FSM keys its transitions and outputs on.
module instr_class_decode
    import mc_ctrl_defs::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e iclass
);

    always_comb begin
        iclass = ClsUndef;
        case (opcode)
            OpRtype: begin
                if (funct == FnJr)        iclass = ClsJreg;
                else if (funct == FnJalr) iclass = ClsJregLink;
                else                      iclass = ClsRtype;
            end
            OpJ:                                        iclass = ClsJump;
            OpJal:                                      iclass = ClsJumpLink;
            OpBeq:                                      iclass = ClsBranch;
            OpLw:                                       iclass = ClsLoad;
            OpSw:                                       iclass = ClsStore;
            OpAddi, OpAddiu, OpSlti, OpAndi, OpLui:     iclass = ClsItype;
            default:                                    iclass = ClsUndef;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath (IF/ID/EX/MEM/WB). Outputs are
// decoded from the current state and instruction class, and forced low in reset.
module multi_cycle_controller
    import mc_ctrl_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [2:0] State
);

    state_e       state_q, state_d;
    instr_class_e iclass;

    instr_class_decode u_decode (
        .opcode (OpCode),
        .funct  (Funct),
        .iclass (iclass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIf;
        else        state_q <= state_d;
    end

    assign State = state_q;

    always_comb begin
        state_d     = StIf;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        MemtoReg    = MemtoRegAluOut;
        RegDst      = RegDstRt;
        ALUSrcA     = SrcAPc;
        ALUSrcB     = SrcBReg;
        PCSource    = PcSrcAlu;
        ALUOp       = AluAdd;

        case (state_q)
            StIf: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = SrcBFour;
                PCWrite = 1'b1;
                state_d = StId;
            end
            StId: begin
                // Branch target is computed speculatively into ALUOut.
                ALUSrcB = SrcBImmSl2;
                ExtOp   = 1'b1;
                state_d = StEx;
                case (iclass)
                    ClsJump, ClsJumpLink: begin
                        PCWrite  = 1'b1;
                        PCSource = PcSrcJump;
                        state_d  = StIf;
                    end
                    ClsJreg, ClsJregLink: begin
                        PCWrite  = 1'b1;
                        PCSource = PcSrcRs;
                        state_d  = StIf;
                    end
                    ClsUndef: state_d = StIf;
                    default:  ;
                endcase
                // Link writes PC (already PC+4) on the same edge PC takes the target.
                if (iclass == ClsJumpLink || iclass == ClsJregLink) begin
                    RegWrite = 1'b1;
                    MemtoReg = MemtoRegPc;
                    RegDst   = (iclass == ClsJumpLink) ? RegDstRa : RegDstRd;
                end
            end
            StEx: begin
                case (iclass)
                    ClsBranch: begin
                        ALUSrcA     = SrcAReg;
                        ALUOp       = AluSub;
                        PCWriteCond = 1'b1;
                        PCSource    = PcSrcAluOut;
                    end
                    ClsLoad, ClsStore: begin
                        ALUSrcA = SrcAReg;
                        ALUSrcB = SrcBImm;
                        ExtOp   = 1'b1;
                        state_d = StMem;
                    end
                    ClsRtype: begin
                        ALUOp   = AluRtype;
                        ALUSrcA = is_shamt_shift(Funct) ? SrcAShamt : SrcAReg;
                        state_d = StWb;
                    end
                    ClsItype: begin
                        ALUSrcA = SrcAReg;
                        ALUSrcB = SrcBImm;
                        state_d = StWb;
                        case (OpCode)
                            OpSlti: begin
                                ALUOp = AluSlt;
                                ExtOp = 1'b1;
                            end
                            OpAndi:  ALUOp = AluAnd;
                            OpLui:   LuiOp = 1'b1;
                            default: ExtOp = 1'b1;
                        endcase
                    end
                    default: ;
                endcase
            end
            StMem: begin
                if (iclass == ClsLoad) begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    state_d = StWb;
                end else if (iclass == ClsStore) begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
            end
            StWb: begin
                RegWrite = 1'b1;
                MemtoReg = (iclass == ClsLoad) ? MemtoRegMdr : MemtoRegAluOut;
                RegDst   = (iclass == ClsRtype) ? RegDstRd : RegDstRt;
            end
            default: state_d = StIf;
        endcase

        // Asynchronous squash: no enable may survive the reset assertion edge.
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            ExtOp       = 1'b0;
            LuiOp       = 1'b0;
            MemtoReg    = 2'd0;
            RegDst      = 2'd0;
            ALUSrcA     = 2'd0;
            ALUSrcB     = 2'd0;
            PCSource    = 2'd0;
            ALUOp       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-instruction expected output
// sequences are queued by the driver and checked cycle by cycle by a monitor.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
    logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [2:0] State;

    multi_cycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .ExtOp       (ExtOp),
        .LuiOp       (LuiOp),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .State       (State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, irw, rw, ext, lui;
        logic [1:0] m2r, rd, sa, sb, pcs;
        logic [3:0] aop;
        logic [2:0] st;
    } ov_t;

    ov_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;
    string cur_name = "reset";

    function automatic ov_t sample();
        ov_t v;
        v.pcw = PCWrite;  v.pcwc = PCWriteCond; v.iord = IorD; v.mr = MemRead;
        v.mw  = MemWrite; v.irw  = IRWrite;     v.rw   = RegWrite; v.ext = ExtOp;
        v.lui = LuiOp;    v.m2r  = MemtoReg;    v.rd   = RegDst;   v.sa  = ALUSrcA;
        v.sb  = ALUSrcB;  v.pcs  = PCSource;    v.aop  = ALUOp;    v.st  = State;
        return v;
    endfunction

    task automatic check(input string name, input ov_t act, input ov_t req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h (state %0d vs %0d)",
                     name, act, req, act.st, req.st);
        end
    endtask

    // Monitor: every cycle with checking enabled consumes one expected vector.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underflow: actual=empty required=entry");
            end else begin
                check(cur_name, sample(), exp_q.pop_front());
            end
        end
    end

    // Reference model: expected output vector per cycle of one instruction.
    task automatic model(input logic [5:0] op, input logic [5:0] fn, output int n);
        ov_t v;
        bit  rtype, ialu, defined;
        n = 0;
        rtype   = (op == 0) && fn != 8 && fn != 9;
        ialu    = op inside {6'd8, 6'd9, 6'd10, 6'd12, 6'd15};
        defined = (op == 0) || ialu || op inside {6'd2, 6'd3, 6'd4, 6'd35, 6'd43};

        v = '0; v.st = 0; v.mr = 1; v.irw = 1; v.sb = 1; v.pcw = 1;
        exp_q.push_back(v); n++;

        v = '0; v.st = 1; v.sb = 3; v.ext = 1;
        if (op == 2 || op == 3) begin
            v.pcw = 1; v.pcs = 2;
            if (op == 3) begin v.rw = 1; v.rd = 2; v.m2r = 2; end
        end else if (op == 0 && (fn == 8 || fn == 9)) begin
            v.pcw = 1; v.pcs = 3;
            if (fn == 9) begin v.rw = 1; v.rd = 1; v.m2r = 2; end
        end
        exp_q.push_back(v); n++;
        if (!defined || op == 2 || op == 3 || (op == 0 && !rtype)) return;

        v = '0; v.st = 2;
        if (op == 4) begin
            v.sa = 1; v.aop = 1; v.pcwc = 1; v.pcs = 1;
            exp_q.push_back(v); n++;
            return;
        end
        if (op == 35 || op == 43) begin
            v.sa = 1; v.sb = 2; v.ext = 1;
            exp_q.push_back(v); n++;
            v = '0; v.st = 3; v.iord = 1;
            if (op == 35) v.mr = 1; else v.mw = 1;
            exp_q.push_back(v); n++;
            if (op == 43) return;
            v = '0; v.st = 4; v.rw = 1; v.m2r = 1;
            exp_q.push_back(v); n++;
            return;
        end
        if (rtype) begin
            v.aop = 2;
            v.sa  = (fn == 0 || fn == 2 || fn == 3) ? 2'd2 : 2'd1;
            exp_q.push_back(v); n++;
            v = '0; v.st = 4; v.rw = 1; v.rd = 1;
            exp_q.push_back(v); n++;
            return;
        end
        v.sa = 1; v.sb = 2;
        case (op)
            8, 9:    v.ext = 1;
            10:      begin v.aop = 4; v.ext = 1; end
            12:      v.aop = 3;
            default: v.lui = 1;
        endcase
        exp_q.push_back(v); n++;
        v = '0; v.st = 4; v.rw = 1;
        exp_q.push_back(v); n++;
    endtask

    // Issue one instruction at posedge+1 and wait out its cycles.
    task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn);
        int n;
        cur_name = name;
        OpCode = op;
        Funct  = fn;
        model(op, fn, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic random_instr();
        logic [5:0] defs[11];
        logic [5:0] specials[10];
        logic [5:0] op, fn;
        int k;
        defs     = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd9, 6'd10, 6'd12, 6'd15, 6'd35, 6'd43};
        specials = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd9, 6'd32, 6'd33, 6'd34, 6'd36, 6'd42};
        fn = 6'($urandom_range(0, 63));
        k  = $urandom_range(0, 12);
        if (k < 11) begin
            op = defs[k];
        end else begin
            do op = 6'($urandom_range(0, 63)); while (op inside {defs});
        end
        if (op == 0 && $urandom_range(0, 1) == 1) fn = specials[$urandom_range(0, 9)];
        issue("random", op, fn);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ov_t zero_v;
        zero_v = '0;
        reset  = 1'b0;
        OpCode = 6'd35;
        Funct  = 6'd0;
        @(posedge clk);
        #1;
        repeat (3) exp_q.push_back(zero_v);
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        issue("addu", 6'd0, 6'd33);
        issue("lw", 6'd35, 6'd0);
        issue("sw", 6'd43, 6'd0);
        issue("beq", 6'd4, 6'd0);
        issue("jal", 6'd3, 6'd0);
        issue("jr", 6'd0, 6'd8);
        issue("jalr", 6'd0, 6'd9);
        issue("sll", 6'd0, 6'd0);
        issue("lui", 6'd15, 6'd5);
        issue("undef63", 6'd63, 6'd0);
        for (int i = 0; i < 150; i++) random_instr();

        // Reset asserted while lw sits in MEM.
        mon_en   = 1'b0;
        cur_name = "lw_reset";
        OpCode   = 6'd35;
        Funct    = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        begin
            ov_t mem_v;
            mem_v = '0; mem_v.st = 3; mem_v.iord = 1; mem_v.mr = 1;
            check("lw_mem_before_reset", sample(), mem_v);
        end
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_in_mem", sample(), zero_v);
        @(posedge clk);
        #1;
        check("reset_held", sample(), zero_v);
        exp_q.delete();
        reset  = 1'b1;
        mon_en = 1'b1;
        issue("after_reset_lw", 6'd35, 6'd7);
        for (int i = 0; i < 30; i++) random_instr();

        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main control FSM of the multi-cycle MIPS processor, directly upstream of the ALU control decoder. It steps each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives datapath enables and mux selects, plus the 4-bit `ALUOp` that the ALU control decoder expands with `Funct`. Outputs are combinational from the current state and the latched instruction fields.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `OpCode`  in  6  instruction[31:26]. Taken from the IR, so it is stable from ID onward.
- `Funct`  in  6  instruction[5:0].
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `ExtOp`, `LuiOp`  out  1 each.
- `MemtoReg`  out  2  selects 0 ALUOut, 1 MDR, 2 PC.
- `RegDst`  out  2  selects 0 rt, 1 rd, 2 $31.
- `ALUSrcA`  out  2  selects 0 PC, 1 A, 2 shamt.
- `ALUSrcB`  out  2  selects 0 B, 1 const 4, 2 ext imm, 3 ext imm<<2.
- `PCSource`  out  2  selects 0 ALU result, 1 ALUOut, 2 jump target, 3 rs read data (direct from regfile).
- `ALUOp`  out  4  values: 0 add, 1 sub, 2 R-type/Funct, 3 and, 4 slt. Bit 3 is always 0 (signed).
- `State`  out  3  current state, for debug.

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5–7 are illegal and return to IF on the next edge.
- Unlisted outputs are 0 in every state.
- **IF**
  - Outputs: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0, PCWrite=1.
  - Next state: always ID.
- **ID**
  - Default outputs: ALUSrcA=0, ALUSrcB=3, ALUOp=0, ExtOp=1. This computes the branch target into ALUOut.
  - j (2): PCWrite=1, PCSource=2.
  - jal (3): as j, plus RegWrite=1, RegDst=2, MemtoReg=2.
  - jr (R, Funct 8): PCWrite=1, PCSource=3.
  - jalr (R, Funct 9): as jr, plus RegWrite=1, RegDst=1, MemtoReg=2.
  - Jumps and undefined opcodes go to IF. Undefined opcodes are NOPs with no writes.
  - All other instructions go to EX.
- **EX**
  - beq (4): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Next state IF.
  - lw (35) / sw (43): ALUSrcA=1, ALUSrcB=2, ALUOp=0, ExtOp=1. Next state MEM.
  - R-type: ALUOp=2, ALUSrcB=0. ALUSrcA=2 for Funct 0/2/3 (sll, srl, sra), else 1. Next state WB.
  - addi (8) / addiu (9): ALUOp=0, ExtOp=1.
  - slti (10): ALUOp=4, ExtOp=1.
  - andi (12): ALUOp=3, ExtOp=0.
  - lui (15): LuiOp=1, ALUOp=0. rs is $0 by encoding.
  - All I-type ALU ops use ALUSrcA=1, ALUSrcB=2. Next state WB.
- **MEM**
  - Both: IorD=1.
  - lw: MemRead=1. Next state WB.
  - sw: MemWrite=1. Next state IF.
- **WB**
  - RegWrite=1.
  - R-type: RegDst=1, MemtoReg=0.
  - I-type ALU: RegDst=0, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
  - Next state: IF.

## Timing
- CPI: jumps and NOPs 2, beq 3, ALU ops and sw 4, lw 5.
- While `reset`=0:
  - State is held at IF.
  - All outputs are forced to 0, including every write enable and MemRead.
  - `State`=0.
- The first IF fetch happens in the first cycle after `reset` rises. State advances on that cycle's clock edge.
- Reset asserted mid-instruction: the state clears immediately and outputs drop to 0 asynchronously. No partial write completes after reset assertion.
- jal/jalr: PC (already PC+4) is written to the regfile on the same edge that PC takes the jump target. The regfile captures the pre-edge value.
- beq: the PC update is qualified externally by PCWriteCond & Zero. The controller does not see Zero.

## Structure
- Shared package/header `mc_ctrl_defs` holds:
  - state codes;
  - opcode constants (R=0, J=2, JAL=3, BEQ=4, ADDI=8, ADDIU=9, SLTI=10, ANDI=12, LUI=15, LW=35, SW=43);
  - Funct JR=8, JALR=9;
  - ALUOp codes;
  - mux-select codes.
- One sub-module, `instr_class_decode`: a combinational map from OpCode/Funct to a class {JUMP, JUMP_LINK, JREG, JREG_LINK, BRANCH, LOAD, STORE, RTYPE, ITYPE, UNDEF}. The FSM keys its transitions and outputs on this class.

## Test plan
- Reset held 3 cycles, then released:
  - during reset, all outputs are 0 and State=0;
  - first cycle after release: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=1.
- addu (R, Funct 33): State sequence 0,1,2,4,0. EX has ALUOp=2, ALUSrcA=1. WB has RegWrite=1, RegDst=1.
- lw: sequence 0,1,2,3,4,0. MEM has IorD=1, MemRead=1. WB has MemtoReg=1, RegDst=0.
- sw: MEM has MemWrite=1, then returns to IF. beq: EX has PCWriteCond=1, ALUOp=1, PCSource=1, then returns to IF.
- jal: ID has PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2, then the next state is IF. jr: ID has PCSource=3 with RegWrite=0.
- Undefined opcode 63 takes IF→ID→IF with no enables asserted. Reset asserted during lw's MEM state: outputs go to 0 immediately and State=0.
